// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite register bank for the filter_resize function core.
// Build option: AXI4L_REG_SLVERR_EN makes unmapped offsets return SLVERR.
module axi4l_reg_slave #(
  parameter int IN_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     user_clk,
  input  logic                     reset_n,
  input  logic [IN_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [DATA_WIDTH-1:0]    s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]  s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [IN_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic                     ctrl_enable,
  output logic                     ctrl_soft_reset,
  output logic [15:0]              ctrl_rows,
  output logic [15:0]              ctrl_cols,
  input  logic [DATA_WIDTH-1:0]    status_in,
  input  logic                     frame_done
);

  localparam int IW = IN_ADDR_WIDTH - 2;
  typedef logic [IW-1:0] idx_t;

  localparam idx_t R_CTRL  = idx_t'(0);
  localparam idx_t R_STAT  = idx_t'(1);
  localparam idx_t R_ROWS  = idx_t'(2);
  localparam idx_t R_COLS  = idx_t'(3);
  localparam idx_t R_FCNT  = idx_t'(4);
  localparam idx_t R_SCR   = idx_t'(5);
  localparam idx_t N_REGS  = idx_t'(6);

  localparam logic [1:0] OKAY = 2'b00;
`ifdef AXI4L_REG_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic                    aw_full;
  idx_t                    aw_idx;
  logic                    w_full;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;

  logic [15:0]           rows_q;
  logic [15:0]           cols_q;
  logic [DATA_WIDTH-1:0] scratch_q;
  logic [31:0]           frame_cnt;
  logic [DATA_WIDTH-1:0] rd_mux;

  logic commit;
  logic w_mapped;
  logic soft_clr;
  idx_t r_idx;
  logic r_mapped;
  logic ar_fire;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0]   old,
    input logic [DATA_WIDTH-1:0]   data,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old;
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

  assign s_axi_awready = ~aw_full;
  assign s_axi_wready  = ~w_full;
  assign s_axi_arready = ~s_axi_rvalid;

  assign commit   = aw_full & w_full & ~s_axi_bvalid;
  assign w_mapped = aw_idx < N_REGS;
  assign soft_clr = commit & (aw_idx == R_CTRL)
                  & w_strb[0] & w_data[1];
  assign r_idx    = s_axi_araddr[IN_ADDR_WIDTH-1:2];
  assign r_mapped = r_idx < N_REGS;
  assign ar_fire  = s_axi_arvalid & ~s_axi_rvalid;

  assign ctrl_rows = rows_q;
  assign ctrl_cols = cols_q;

  always_comb begin
    rd_mux = '0;
    case (r_idx)
      R_CTRL:  rd_mux = DATA_WIDTH'({ctrl_enable});
      R_STAT:  rd_mux = status_in;
      R_ROWS:  rd_mux = DATA_WIDTH'(rows_q);
      R_COLS:  rd_mux = DATA_WIDTH'(cols_q);
      R_FCNT:  rd_mux = DATA_WIDTH'(frame_cnt);
      R_SCR:   rd_mux = scratch_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (s_axi_awvalid && !aw_full) begin
        aw_full <= 1'b1;
        aw_idx  <= s_axi_awaddr[IN_ADDR_WIDTH-1:2];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (s_axi_wvalid && !w_full) begin
        w_full <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= OKAY;
    end else if (commit) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= w_mapped ? OKAY : ERR;
    end else if (s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  // Unmapped offsets fall through the case and are dropped.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_enable     <= 1'b0;
      ctrl_soft_reset <= 1'b0;
      rows_q          <= '0;
      cols_q          <= '0;
      scratch_q       <= '0;
    end else begin
      ctrl_soft_reset <= soft_clr;
      if (commit) begin
        case (aw_idx)
          R_CTRL: if (w_strb[0]) ctrl_enable <= w_data[0];
          R_ROWS: rows_q <= 16'(merge(DATA_WIDTH'(rows_q), w_data, w_strb));
          R_COLS: cols_q <= 16'(merge(DATA_WIDTH'(cols_q), w_data, w_strb));
          R_SCR:  scratch_q <= merge(scratch_q, w_data, w_strb);
          default: ;
        endcase
      end
    end
  end

  // Clear lands with the soft-reset pulse and beats a coincident frame.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n)        frame_cnt <= '0;
    else if (soft_clr)   frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 32'd1;
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= OKAY;
    end else if (ar_fire) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_mux;
      s_axi_rresp  <= r_mapped ? OKAY : ERR;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Directed bench for axi4l_reg_slave.
// Honours AXI4L_REG_SLVERR_EN for the unmapped-offset response.
module tb_axi4l_reg_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [15:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        ctrl_enable;
  logic        ctrl_soft_reset;
  logic [15:0] ctrl_rows;
  logic [15:0] ctrl_cols;
  logic [31:0] status_in = '0;
  logic        frame_done = 1'b0;

`ifdef AXI4L_REG_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  axi4l_reg_slave dut (
    .user_clk        (clk),
    .reset_n         (reset_n),
    .s_axi_awaddr    (awaddr),
    .s_axi_awprot    (awprot),
    .s_axi_awvalid   (awvalid),
    .s_axi_awready   (awready),
    .s_axi_wdata     (wdata),
    .s_axi_wstrb     (wstrb),
    .s_axi_wvalid    (wvalid),
    .s_axi_wready    (wready),
    .s_axi_bresp     (bresp),
    .s_axi_bvalid    (bvalid),
    .s_axi_bready    (bready),
    .s_axi_araddr    (araddr),
    .s_axi_arprot    (arprot),
    .s_axi_arvalid   (arvalid),
    .s_axi_arready   (arready),
    .s_axi_rdata     (rdata),
    .s_axi_rresp     (rresp),
    .s_axi_rvalid    (rvalid),
    .s_axi_rready    (rready),
    .ctrl_enable     (ctrl_enable),
    .ctrl_soft_reset (ctrl_soft_reset),
    .ctrl_rows       (ctrl_rows),
    .ctrl_cols       (ctrl_cols),
    .status_in       (status_in),
    .frame_done      (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic wait_aw_w_ready();
    int n = 0;
    while (!(awready && wready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("aw_w_ready_timeout", {30'd0, awready, wready}, 32'h3);
  endtask

  task automatic wait_b();
    int n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("bvalid_timeout", {31'd0, bvalid}, 32'h1);
  endtask

  task automatic wait_r();
    int n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rvalid_timeout", {31'd0, rvalid}, 32'h1);
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    wait_aw_w_ready();
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b();
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n = 0;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("arready_timeout", {31'd0, arready}, 32'h1);
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    wait_r();
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic [1:0]  ws;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'h1);
    chk("rst_wready", {31'd0, wready}, 32'h1);
    chk("rst_arready", {31'd0, arready}, 32'h1);
    chk("rst_bvalid", {31'd0, bvalid}, 32'h0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_soft", {31'd0, ctrl_soft_reset}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      axi_read(16'(i * 4), rd, rs);
      chk($sformatf("init_rdata_%0h", i * 4), rd, 32'h0);
      chk($sformatf("init_rresp_%0h", i * 4), {30'd0, rs}, 32'h0);
    end

    status_in = 32'hDEAD_BEEF;
    axi_read(16'h04, rd, rs);
    chk("status_read", rd, 32'hDEAD_BEEF);

    // AW at cycle 0, W at cycle 3, B at cycle 5
    awaddr = 16'h14; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("aw_held_awready", {31'd0, awready}, 32'h0);
    chk("aw_held_wready", {31'd0, wready}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    wdata = 32'hA5A5_1234; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("late_w_bvalid_c4", {31'd0, bvalid}, 32'h0);
    @(negedge clk);
    chk("late_w_bvalid_c5", {31'd0, bvalid}, 32'h1);
    chk("late_w_bresp", {30'd0, bresp}, 32'h0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_handshake_clears", {31'd0, bvalid}, 32'h0);
    axi_read(16'h14, rd, rs);
    chk("scratch_read", rd, 32'hA5A5_1234);

    // byte strobes on ROWS
    axi_write(16'h08, 32'hFFFF_BEEF, 4'h1, ws);
    chk("rows_strb1", {16'd0, ctrl_rows}, 32'h0000_00EF);
    axi_write(16'h08, 32'h0000_1200, 4'h2, ws);
    chk("rows_strb2", {16'd0, ctrl_rows}, 32'h0000_12EF);
    axi_read(16'h08, rd, rs);
    chk("rows_read", rd, 32'h0000_12EF);

    // frame counter and soft reset
    repeat (3) begin
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      @(negedge clk);
    end
    axi_read(16'h10, rd, rs);
    chk("fcnt_3", rd, 32'h3);
    wait_aw_w_ready();
    awaddr = 16'h00; awvalid = 1'b1;
    wdata = 32'h3; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    frame_done = 1'b1;
    chk("soft_pre", {31'd0, ctrl_soft_reset}, 32'h0);
    @(negedge clk);
    frame_done = 1'b0;
    chk("soft_pulse", {31'd0, ctrl_soft_reset}, 32'h1);
    chk("soft_enable", {31'd0, ctrl_enable}, 32'h1);
    chk("soft_bvalid", {31'd0, bvalid}, 32'h1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("soft_one_cycle", {31'd0, ctrl_soft_reset}, 32'h0);
    axi_read(16'h10, rd, rs);
    chk("fcnt_cleared", rd, 32'h0);
    axi_read(16'h00, rd, rs);
    chk("control_read", rd, 32'h1);
    chk("rows_kept", {16'd0, ctrl_rows}, 32'h0000_12EF);

    // read and write commit to SCRATCH in the same cycle
    wait_aw_w_ready();
    awaddr = 16'h14; awvalid = 1'b1;
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 16'h14; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rw_rvalid", {31'd0, rvalid}, 32'h1);
    chk("rw_prewrite", rdata, 32'hA5A5_1234);
    chk("rw_bvalid", {31'd0, bvalid}, 32'h1);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    axi_read(16'h14, rd, rs);
    chk("rw_postwrite", rd, 32'h0BAD_F00D);

    // zero strobe: response but no write
    axi_write(16'h14, 32'hFFFF_FFFF, 4'h0, ws);
    chk("strb0_bresp", {30'd0, ws}, 32'h0);
    axi_read(16'h14, rd, rs);
    chk("strb0_nowrite", rd, 32'h0BAD_F00D);

    // back-pressured B with a second write queued
    wait_aw_w_ready();
    awaddr = 16'h0C; awvalid = 1'b1;
    wdata = 32'h9ABC_5678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (10) @(negedge clk);
    chk("bp_bvalid_hold", {31'd0, bvalid}, 32'h1);
    chk("bp_cols", {16'd0, ctrl_cols}, 32'h0000_5678);
    chk("bp_awready_free", {31'd0, awready}, 32'h1);
    awaddr = 16'h14; awvalid = 1'b1;
    wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_awready_full", {31'd0, awready}, 32'h0);
    chk("bp_wready_full", {31'd0, wready}, 32'h0);
    repeat (3) @(negedge clk);
    chk("bp_still_held", {30'd0, awready, wready}, 32'h0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bp_b1_done", {31'd0, bvalid}, 32'h0);
    @(negedge clk);
    chk("bp_b2_valid", {31'd0, bvalid}, 32'h1);
    chk("bp_freed", {30'd0, awready, wready}, 32'h3);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    axi_read(16'h14, rd, rs);
    chk("bp_second_write", rd, 32'h1111_2222);
    axi_read(16'h0C, rd, rs);
    chk("bp_cols_read", rd, 32'h0000_5678);

    // unmapped offset
    axi_read(16'h40, rd, rs);
    chk("unmap_rdata", rd, 32'h0);
    chk("unmap_rresp", {30'd0, rs}, {30'd0, EXP_ERR});
    axi_write(16'h40, 32'hFFFF_FFFF, 4'hF, ws);
    chk("unmap_bresp", {30'd0, ws}, {30'd0, EXP_ERR});
    axi_read(16'h14, rd, rs);
    chk("unmap_no_alias", rd, 32'h1111_2222);

    // frame counter wrap
    force dut.frame_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    axi_read(16'h10, rd, rs);
    chk("fcnt_preset", rd, 32'hFFFF_FFFF);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    axi_read(16'h10, rd, rs);
    chk("fcnt_wrap", rd, 32'h0);

    // reset with AW held mid-transaction
    awaddr = 16'h14; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("mid_aw_held", {31'd0, awready}, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("mid_awready", {31'd0, awready}, 32'h1);
    chk("mid_rows", {16'd0, ctrl_rows}, 32'h0);
    chk("mid_enable", {31'd0, ctrl_enable}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wdata = 32'hCAFE_CAFE; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_no_b", {31'd0, bvalid}, 32'h0);
    chk("mid_scratch_clr", dut.scratch_q, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
